mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Memory/I-O access controller between the multicycle CPU datapath and its data memory and board peripherals. Accepts one word-sized load or store at a time over a req/ready handshake, decodes the address into data memory (DMEM) or memory-mapped I/O (HEX, LEDR, KEY, SW), and sequences the synchronous-RAM access. It also owns the HEX/LEDR output registers and the KEY/SW input synchronizers. The CPU control FSM holds in its memory states until `ready`.

## Interface
- DBITS, 32, data/address width
- DMEMADDRBITS, 16, byte-address bits decoded as DMEM
- DMEMWORDBITS, 2, byte-offset bits below the word index
- ADDRHEX, 32'hFFFFF000, HEX display register address
- ADDRLEDR, 32'hFFFFF020, LED register address
- ADDRKEY, 32'hFFFFF080, key input address (read-only)
- ADDRSW, 32'hFFFFF090, switch input address (read-only)

One clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- req  in  1  access request, held until `ready`
- we  in  1  1 = store, 0 = load
- addr  in  DBITS  byte address
- wdata  in  DBITS  store data
- ready  out  1  one-cycle completion pulse
- rdata  out  DBITS  load data, valid while `ready`=1
- err  out  1  access fault, valid while `ready`=1
- dm_addr  out  DMEMADDRBITS-DMEMWORDBITS  DMEM word index
- dm_we  out  1  DMEM write strobe
- dm_wdata  out  DBITS  DMEM write data
- dm_rdata  in  DBITS  DMEM read data, one cycle after `dm_addr` is presented
- hex_val  out  24  six hex digits, to the 7-seg decoders
- ledr  out  10  LED drive
- key_n  in  4  raw board keys, active-low, asynchronous
- sw  in  10  raw switches, asynchronous

## Operation
- States: IDLE, ACCESS, RDWAIT, DONE.
- IDLE: on `req`=1, latch `addr`, `we`, `wdata`. Classify as DMEM, HEX, LEDR, KEY, SW or BAD, then go to ACCESS. Later input changes are ignored until the next IDLE.
- Decode rules:
  - DMEM: `addr[DBITS-1:DMEMADDRBITS]`==0.
  - I/O: exact match of the four addresses.
  - BAD: `addr[1:0]`!=0, any other address, or a store to KEY or SW.
- ACCESS:
  - DMEM store: `dm_we`=1, `dm_addr`=latched addr[15:2], `dm_wdata`=latched wdata; then DONE.
  - DMEM load: present `dm_addr`; then RDWAIT.
  - HEX store: `hex_val` <= wdata[23:0]. LEDR store: `ledr` <= wdata[9:0].
  - HEX/LEDR load: capture the register value zero-extended into `rdata`.
  - KEY load: `rdata` = {28'b0, key_sync}. SW load: `rdata` = {22'b0, sw_sync}.
  - BAD: no side effect, `rdata` = 0, set error flag.
  - All non-DMEM-load cases go to DONE.
- RDWAIT: capture `dm_rdata` into `rdata`; then DONE.
- DONE: `ready`=1, `err`=error flag; return to IDLE. A `req` sampled in DONE is ignored; it is accepted in the following IDLE cycle.
- key_sync: 2-flop synchronizer of `~key_n`, so 1 = pressed. sw_sync: 2-flop synchronizer of `sw`.
- `dm_we` is 1 only in ACCESS for a DMEM store; it is never asserted for any other access, including BAD.

## Timing
- Request sampled in IDLE at edge 0. Completion (`ready`=1) after:
  - DMEM store and all I/O/BAD accesses: 2 cycles.
  - DMEM load: 3 cycles.
- Maximum throughput: one access per 3 cycles (non-load) or 4 cycles (load).
- `rdata` and `err` are registered and hold their value until the next access's DONE/ACCESS update.
- Input synchronizer latency: 2 cycles from pin to key_sync/sw_sync.
- Reset values:
  - state = IDLE.
  - `ready`, `err`, `dm_we` = 0.
  - `rdata`, `dm_addr`, `dm_wdata`, `hex_val`, `ledr` = 0.
  - key_sync, sw_sync = 0.
- Reset mid-access: abort immediately to IDLE with all outputs at reset values. No `ready` pulse; a partially issued store is not re-issued.
- `req` deasserted before `ready`: the latched access still completes and pulses `ready`.
- Word index wraps naturally within 14 bits. No access can reach DMEM above 0xFFFC.

## Test plan
- Store 0x12345678 to 0x00000040, then load 0x00000040:
  - `dm_we` pulses once with `dm_addr`=0x10.
  - Load returns `ready` at cycle 3 with `rdata`=0x12345678, `err`=0.
- Store 0xABCDEF01 to ADDRHEX and 0x3FF to ADDRLEDR:
  - `hex_val`=0xCDEF01, `ledr`=0x3FF.
  - Readback gives 0x00CDEF01 and 0x000003FF. `dm_we` stays 0 throughout.
- `key_n`=4'b1010, `sw`=10'h155, wait 3 cycles, load ADDRKEY and ADDRSW -> `rdata`=0x5 and 0x155.
- Bad accesses each give `ready` with `err`=1, no `dm_we`, and unchanged `hex_val`/`ledr`:
  - Load 0x00000042.
  - Store to ADDRSW.
  - Load 0x80000000.
- Assert RESET_N=0 during RDWAIT of a load:
  - No `ready` pulse; all outputs go to 0.
  - After release, a new DMEM store completes in 2 cycles.
- Hold `req`=1 continuously with alternating stores -> exactly one `ready` per 3 cycles, each access using the address latched at its own IDLE.

Source files
------------

// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/response bus of the memory/I-O controller.
// The CPU drives req/we/addr/wdata; the controller answers with ready/rdata/err.
interface mem_io_ctrl_if #(
  parameter int unsigned DBITS = 32
);
  logic             req;
  logic             we;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             ready;
  logic [DBITS-1:0] rdata;
  logic             err;

  modport master (output req, we, addr, wdata, input  ready, rdata, err);
  modport slave  (input  req, we, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/I-O access controller: one word load/store at a time, decoded to DMEM
// or memory-mapped HEX/LEDR/KEY/SW, with synchronous-RAM read sequencing.
module mem_io_ctrl #(
  parameter int unsigned       DBITS        = 32,
  parameter int unsigned       DMEMADDRBITS = 16,
  parameter int unsigned       DMEMWORDBITS = 2,
  parameter logic [DBITS-1:0]  ADDRHEX      = 32'hFFFFF000,
  parameter logic [DBITS-1:0]  ADDRLEDR     = 32'hFFFFF020,
  parameter logic [DBITS-1:0]  ADDRKEY      = 32'hFFFFF080,
  parameter logic [DBITS-1:0]  ADDRSW       = 32'hFFFFF090
) (
  input  logic                                 clk,
  input  logic                                 RESET_N,
  mem_io_ctrl_if.slave                         bus,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dm_addr,
  output logic                                 dm_we,
  output logic [DBITS-1:0]                     dm_wdata,
  input  logic [DBITS-1:0]                     dm_rdata,
  output logic [23:0]                          hex_val,
  output logic [9:0]                           ledr,
  input  logic [3:0]                           key_n,
  input  logic [9:0]                           sw
);

  localparam int unsigned WIDXBITS = DMEMADDRBITS - DMEMWORDBITS;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_DONE} state_e;
  typedef enum logic [2:0] {K_DMEM, K_HEX, K_LEDR, K_KEY, K_SW, K_BAD} kind_e;

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic                we_q, we_d;
  logic [WIDXBITS-1:0] widx_q, widx_d;
  logic [DBITS-1:0]    wdata_q, wdata_d;
  logic [DBITS-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [23:0]         hex_q, hex_d;
  logic [9:0]          ledr_q, ledr_d;
  logic [3:0]          key_s1_q, key_sync_q;
  logic [9:0]          sw_s1_q, sw_sync_q;

  // Misaligned wins over everything; KEY/SW are read-only so stores there fault.
  function automatic kind_e decode(input logic w, input logic [DBITS-1:0] a);
    kind_e k;
    if (a[1:0] != 2'b00)                         k = K_BAD;
    else if (a[DBITS-1:DMEMADDRBITS] == '0)      k = K_DMEM;
    else if (a == ADDRHEX)                       k = K_HEX;
    else if (a == ADDRLEDR)                      k = K_LEDR;
    else if (a == ADDRKEY && !w)                 k = K_KEY;
    else if (a == ADDRSW && !w)                  k = K_SW;
    else                                         k = K_BAD;
    return k;
  endfunction

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      kind_q     <= K_DMEM;
      we_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      hex_q      <= '0;
      ledr_q     <= '0;
      key_s1_q   <= '0;
      key_sync_q <= '0;
      sw_s1_q    <= '0;
      sw_sync_q  <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      we_q       <= we_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      key_s1_q   <= ~key_n;
      key_sync_q <= key_s1_q;
      sw_s1_q    <= sw;
      sw_sync_q  <= sw_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    we_d    = we_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    dm_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          widx_d  = bus.addr[DMEMADDRBITS-1:DMEMWORDBITS];
          wdata_d = bus.wdata;
          kind_d  = decode(bus.we, bus.addr);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        err_d   = 1'b0;
        unique case (kind_q)
          K_DMEM: begin
            if (we_q) dm_we = 1'b1;
            else      state_d = S_RDWAIT;
          end
          K_HEX: begin
            if (we_q) hex_d = wdata_q[23:0];
            else      rdata_d = DBITS'(hex_q);
          end
          K_LEDR: begin
            if (we_q) ledr_d = wdata_q[9:0];
            else      rdata_d = DBITS'(ledr_q);
          end
          K_KEY:   rdata_d = DBITS'(key_sync_q);
          K_SW:    rdata_d = DBITS'(sw_sync_q);
          default: begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        endcase
      end
      S_RDWAIT: begin
        rdata_d = dm_rdata;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready = (state_q == S_DONE);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign dm_addr   = widx_q;
  assign dm_wdata  = wdata_q;
  assign hex_val   = hex_q;
  assign ledr      = ledr_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl with a behavioural synchronous DMEM.
module tb_mem_io_ctrl;

  localparam logic [31:0] ADDRHEX  = 32'hFFFFF000;
  localparam logic [31:0] ADDRLEDR = 32'hFFFFF020;
  localparam logic [31:0] ADDRKEY  = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW   = 32'hFFFFF090;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [13:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = '0;
  logic [23:0] hex_val;
  logic [9:0]  ledr;
  logic [3:0]  key_n;
  logic [9:0]  sw;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int ready_cnt = 0;
  logic [13:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;
  logic [31:0] mem [16384];

  mem_io_ctrl_if #(.DBITS(32)) bus ();

  mem_io_ctrl #(
    .DBITS(32), .DMEMADDRBITS(16), .DMEMWORDBITS(2),
    .ADDRHEX(ADDRHEX), .ADDRLEDR(ADDRLEDR), .ADDRKEY(ADDRKEY), .ADDRSW(ADDRSW)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .bus(bus),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .hex_val(hex_val), .ledr(ledr), .key_n(key_n), .sw(sw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    dm_rdata <= mem[dm_addr];
  end

  always @(negedge clk) begin
    if (dm_we) begin
      we_cnt++;
      last_we_addr = dm_addr;
      last_we_data = dm_wdata;
    end
    if (bus.ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one access and returns the edge count from the sampling edge to ready.
  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int cyc);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    cyc = 0;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready) break;
    end
    rd = bus.rdata;
    e  = bus.err;
    bus.req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          cyc;
    int          n;
    int          wc0;
    int          rc0;
    logic [23:0] hex0;
    logic [9:0]  ledr0;

    for (int i = 0; i < 16384; i++) mem[i] = '0;
    RESET_N = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    key_n = 4'hF; sw = '0;
    #12;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_rdata", bus.rdata,      32'd0);
    check("rst_hex",   32'(hex_val),   32'd0);
    check("rst_ledr",  32'(ledr),      32'd0);
    check("rst_dmwe",  32'(dm_we),     32'd0);
    @(negedge clk); RESET_N = 1'b1;

    // DMEM store then load
    wc0 = we_cnt;
    run(1'b1, 32'h00000040, 32'h12345678, rd, e, cyc);
    check("st_cycles",  32'(cyc), 32'd2);
    check("st_wecnt",   32'(we_cnt - wc0), 32'd1);
    check("st_dmaddr",  32'(last_we_addr), 32'h10);
    check("st_dmwdata", last_we_data, 32'h12345678);
    check("st_err",     32'(e), 32'd0);
    run(1'b0, 32'h00000040, 32'h0, rd, e, cyc);
    check("ld_cycles", 32'(cyc), 32'd3);
    check("ld_rdata",  rd, 32'h12345678);
    check("ld_err",    32'(e), 32'd0);
    check("ld_wecnt",  32'(we_cnt - wc0), 32'd1);

    // HEX / LEDR stores and readback
    wc0 = we_cnt;
    run(1'b1, ADDRHEX, 32'hABCDEF01, rd, e, cyc);
    check("hex_cycles", 32'(cyc), 32'd2);
    check("hex_val",    32'(hex_val), 32'h00CDEF01);
    run(1'b1, ADDRLEDR, 32'h000003FF, rd, e, cyc);
    check("ledr_val",   32'(ledr), 32'h3FF);
    run(1'b0, ADDRHEX, 32'h0, rd, e, cyc);
    check("hex_rd",     rd, 32'h00CDEF01);
    check("hex_rd_cyc", 32'(cyc), 32'd2);
    run(1'b0, ADDRLEDR, 32'h0, rd, e, cyc);
    check("ledr_rd",    rd, 32'h000003FF);
    check("io_wecnt",   32'(we_cnt - wc0), 32'd0);

    // KEY / SW through synchronizers
    key_n = 4'b1010; sw = 10'h155;
    repeat (3) @(posedge clk);
    run(1'b0, ADDRKEY, 32'h0, rd, e, cyc);
    check("key_rd",  rd, 32'h5);
    check("key_err", 32'(e), 32'd0);
    run(1'b0, ADDRSW, 32'h0, rd, e, cyc);
    check("sw_rd",   rd, 32'h155);

    // Faulting accesses
    wc0 = we_cnt; hex0 = hex_val; ledr0 = ledr;
    run(1'b0, 32'h00000042, 32'h0, rd, e, cyc);
    check("bad_mis_err", 32'(e), 32'd1);
    check("bad_mis_rd",  rd, 32'h0);
    check("bad_mis_cyc", 32'(cyc), 32'd2);
    run(1'b1, ADDRSW, 32'hFFFFFFFF, rd, e, cyc);
    check("bad_sw_err",  32'(e), 32'd1);
    run(1'b0, 32'h80000000, 32'h0, rd, e, cyc);
    check("bad_hi_err",  32'(e), 32'd1);
    check("bad_hi_rd",   rd, 32'h0);
    check("bad_wecnt",   32'(we_cnt - wc0), 32'd0);
    check("bad_hex",     32'(hex_val), 32'(hex0));
    check("bad_ledr",    32'(ledr), 32'(ledr0));

    // Reset during RDWAIT of a load
    rc0 = ready_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h00000040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RESET_N = 1'b0; bus.req = 1'b0;
    #1;
    check("mr_ready",  32'(bus.ready), 32'd0);
    check("mr_err",    32'(bus.err), 32'd0);
    check("mr_rdata",  bus.rdata, 32'd0);
    check("mr_hex",    32'(hex_val), 32'd0);
    check("mr_ledr",   32'(ledr), 32'd0);
    check("mr_dmaddr", 32'(dm_addr), 32'd0);
    check("mr_dmwd",   dm_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); RESET_N = 1'b1;
    repeat (2) @(posedge clk);
    check("mr_noready", 32'(ready_cnt - rc0), 32'd0);
    wc0 = we_cnt;
    run(1'b1, 32'h00000080, 32'h000055AA, rd, e, cyc);
    check("mr_st_cyc",  32'(cyc), 32'd2);
    check("mr_st_addr", 32'(last_we_addr), 32'h20);
    check("mr_st_we",   32'(we_cnt - wc0), 32'd1);

    // Back-to-back stores with req held; inputs scrambled once each access is latched
    wc0 = we_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h100; bus.wdata = 32'hA0A00000;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (n < 10) begin
        @(posedge clk); #1;
        n++;
        if (n == ((k == 0) ? 1 : 2)) begin
          bus.addr = 32'hDEAD0000; bus.wdata = 32'hFFFFFFFF;
        end
        if (bus.ready) break;
      end
      check("stream_gap",   32'(n), (k == 0) ? 32'd2 : 32'd3);
      check("stream_addr",  32'(last_we_addr), ((k % 2) == 0) ? 32'h40 : 32'h41);
      check("stream_wdata", last_we_data, 32'hA0A00000 | 32'(k));
      bus.addr  = ((k % 2) == 0) ? 32'h104 : 32'h100;
      bus.wdata = 32'hA0A00000 | 32'(k + 1);
    end
    bus.req = 1'b0;
    check("stream_wecnt", 32'(we_cnt - wc0), 32'd4);
    @(posedge clk); #1;
    run(1'b0, 32'h00000100, 32'h0, rd, e, cyc);
    check("stream_rd0", rd, 32'hA0A00002);
    run(1'b0, 32'h00000104, 32'h0, rd, e, cyc);
    check("stream_rd1", rd, 32'hA0A00003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
